tlul_reg_slave: RTL

- TL-UL slave endpoint that consumes the master-driven channel-A bundle (tl_chA_t) and produces the slave-driven channel-D bundle (tl_chD_t).
- Converts accepted TL-UL Get/PutFullData/PutPartialData beats into single-beat requests on a simple local register port, then returns the TL-UL response.
- Sits between the TL-UL crossbar/driver and a core's register file (e.g. LLKI key/status registers).
- One outstanding transaction at a time.

---
 rtl/tlul_pkg.sv | 87 ++++++++
 rtl/tlul_reg_slave_if.sv | 28 ++
 rtl/tlul_reg_slave.sv | 114 +++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// TL-UL shared types, opcode values and the reusable request-legality check.
// Also holds the state enum and captured-request struct used by tlul_reg_slave.
package tlul_pkg;

    localparam int unsigned MAX_TIMEOUT = 100;

    localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_ARITH       = 3'd2;
    localparam logic [2:0] TL_A_LOGIC       = 3'd3;
    localparam logic [2:0] TL_A_GET         = 3'd4;

    localparam logic [2:0] TL_D_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACK_DATA = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_param;
        logic [2:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [7:0]  a_mask;
        logic [63:0] a_data;
        logic        a_corrupt;
        logic        d_ready;
    } tl_chA_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [2:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [63:0] d_data;
        logic        d_denied;
        logic        d_corrupt;
        logic        a_ready;
    } tl_chD_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHK  = 2'd1,
        ST_REQ  = 2'd2,
        ST_RESP = 2'd3
    } reg_slave_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic [7:0]  source;
        logic [2:0]  opcode;
        logic [2:0]  size;
    } reg_slave_req_t;

    // Legal = supported opcode, size <= 8 bytes, naturally aligned, inside
    // [base, base + 2^addr_w), and no corrupt flag on a Put.
    function automatic logic tlul_req_legal(
        input logic [2:0]  opcode,
        input logic [2:0]  size,
        input logic [31:0] addr,
        input logic        corrupt,
        input logic [31:0] base,
        input int unsigned addr_w
    );
        logic        op_ok;
        logic        is_put;
        logic        align_ok;
        logic [32:0] off;
        logic        range_ok;
        is_put = (opcode == TL_A_PUT_FULL) || (opcode == TL_A_PUT_PARTIAL);
        op_ok  = is_put || (opcode == TL_A_GET);
        case (size)
            3'd0:    align_ok = 1'b1;
            3'd1:    align_ok = (addr[0] == 1'b0);
            3'd2:    align_ok = (addr[1:0] == 2'b00);
            3'd3:    align_ok = (addr[2:0] == 3'b000);
            default: align_ok = 1'b0;
        endcase
        off      = {1'b0, addr} - {1'b0, base};
        range_ok = !off[32] && ((off[31:0] >> addr_w) == 32'd0);
        return op_ok && align_ok && range_ok && !(is_put && corrupt);
    endfunction

endpackage

// File: rtl/tlul_reg_slave_if.sv
// Bus bundle for tlul_reg_slave: TL-UL A/D channels plus the local register port.
interface tlul_reg_slave_if #(
    parameter int ADDR_W = 12
);
    import tlul_pkg::*;

    tl_chA_t            tl_a;
    tl_chD_t            tl_d;
    logic               reg_req;
    logic               reg_we;
    logic [ADDR_W-1:0]  reg_addr;
    logic [63:0]        reg_wdata;
    logic [7:0]         reg_be;
    logic               reg_ack;
    logic [63:0]        reg_rdata;
    logic               reg_err;

    modport slave (
        input  tl_a, reg_ack, reg_rdata, reg_err,
        output tl_d, reg_req, reg_we, reg_addr, reg_wdata, reg_be
    );

    modport master (
        output tl_a, reg_ack, reg_rdata, reg_err,
        input  tl_d, reg_req, reg_we, reg_addr, reg_wdata, reg_be
    );

endinterface

// File: rtl/tlul_reg_slave.sv
// TL-UL to simple register-port bridge, one transaction outstanding.
// Optional register-ack timeout enabled by defining TLUL_REG_SLAVE_TIMEOUT_EN.
module tlul_reg_slave
    import tlul_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h7000_0000,
    parameter int          ADDR_W    = 12,
    parameter int          TIMEOUT   = MAX_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    tlul_reg_slave_if.slave    bus
);

    reg_slave_state_e  state;
    reg_slave_req_t    req;
    logic              corrupt;
    logic              denied;
    logic [63:0]       rdata;
    logic              legal;
    logic              is_get;
    logic [ADDR_W-1:0] win_off;
    logic              unused_param;

    assign unused_param = ^bus.tl_a.a_param;
    assign legal   = tlul_req_legal(req.opcode, req.size, req.addr, corrupt,
                                    BASE_ADDR, ADDR_W);
    assign is_get  = (req.opcode == TL_A_GET);
    assign win_off = req.addr[ADDR_W-1:0] - BASE_ADDR[ADDR_W-1:0];

`ifdef TLUL_REG_SLAVE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic             expired;

    always_ff @(posedge clk) begin
        if (rst || state != ST_REQ) cnt <= '0;
        else                        cnt <= cnt + CNT_W'(1);
    end

    // Fires in the TIMEOUT-th REQ cycle; a same-cycle ack is checked first.
    assign expired = (cnt == CNT_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            denied <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.tl_a.a_valid) state <= ST_CHK;
                ST_CHK: begin
                    denied <= !legal;
                    state  <= legal ? ST_REQ : ST_RESP;
                end
                ST_REQ: begin
                    if (bus.reg_ack) begin
                        denied <= bus.reg_err;
                        state  <= ST_RESP;
                    end
`ifdef TLUL_REG_SLAVE_TIMEOUT_EN
                    else if (expired) begin
                        denied <= 1'b1;
                        state  <= ST_RESP;
                    end
`endif
                end
                ST_RESP: if (bus.tl_a.d_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Captured request and read data carry no reset; outputs are gated by state.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.tl_a.a_valid) begin
            req.addr   <= bus.tl_a.a_address;
            req.mask   <= bus.tl_a.a_mask;
            req.data   <= bus.tl_a.a_data;
            req.source <= bus.tl_a.a_source;
            req.opcode <= bus.tl_a.a_opcode;
            req.size   <= bus.tl_a.a_size;
            corrupt    <= bus.tl_a.a_corrupt;
        end
        if (state == ST_REQ && bus.reg_ack) rdata <= bus.reg_rdata;
    end

    always_comb begin
        bus.tl_d      = '0;
        bus.reg_req   = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        bus.reg_be    = '0;
        bus.tl_d.a_ready = (state == ST_IDLE) && !rst;
        if (state == ST_REQ) begin
            bus.reg_req   = 1'b1;
            bus.reg_we    = !is_get;
            bus.reg_addr  = win_off & {{(ADDR_W-3){1'b1}}, 3'b000};
            bus.reg_wdata = req.data;
            bus.reg_be    = req.mask;
        end
        if (state == ST_RESP) begin
            bus.tl_d.d_valid   = 1'b1;
            bus.tl_d.d_opcode  = is_get ? TL_D_ACK_DATA : TL_D_ACK;
            bus.tl_d.d_size    = req.size;
            bus.tl_d.d_source  = req.source;
            bus.tl_d.d_denied  = denied;
            bus.tl_d.d_corrupt = denied && is_get;
            bus.tl_d.d_data    = (is_get && !denied) ? rdata : 64'd0;
        end
    end

endmodule
